// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ISA widths, fetch sequencer states and the
// instruction-type encodings decoded by the control unit.
package cpu_pkg;

    localparam int INSTR_W = 9;
    localparam int OP_W    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } fetch_state_t;

    // Instruction type lives in the top OP_W bits of the 9-bit word.
    localparam logic [OP_W-1:0] OP_ALU   = 3'd0;
    localparam logic [OP_W-1:0] OP_ALUI  = 3'd1;
    localparam logic [OP_W-1:0] OP_LOAD  = 3'd2;
    localparam logic [OP_W-1:0] OP_STORE = 3'd3;
    localparam logic [OP_W-1:0] OP_BR    = 3'd4;
    localparam logic [OP_W-1:0] OP_JMP   = 3'd5;
    localparam logic [OP_W-1:0] OP_IO    = 3'd6;
    localparam logic [OP_W-1:0] OP_HALT  = 3'd7;

    function automatic logic [OP_W-1:0] instr_op(input logic [INSTR_W-1:0] ins);
        return ins[INSTR_W-1 -: OP_W];
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: owns the PC, drives the synchronous ROM and
// presents one instruction per cycle to the control unit.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int PC_W    = 10,
    parameter int INSTR_W = cpu_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stall,
    input  logic               jump,
    input  logic [PC_W-1:0]    jump_target,
    input  logic               halt_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [PC_W-1:0]    pc,
    output logic               done,
    output fetch_state_t       dbg_state
);

    // Handshake: instr is consumed on every rising edge where instr_valid=1
    // and stall=0; jump/halt_req qualify that same presented instruction.

    fetch_state_t    state_q,    state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0] exec_pc_q,  exec_pc_d;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        exec_pc_d  = exec_pc_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    fetch_pc_d = '0;
                    state_d    = PRIME;
                end
            end
            PRIME: begin
                exec_pc_d  = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + PC_W'(1);
                state_d    = RUN;
            end
            RUN: begin
                if (stall) begin
                    state_d = RUN;
                end else if (halt_req) begin
                    state_d = DONE;
                end else if (jump) begin
                    // The word read this cycle is dropped; PRIME refills from the target.
                    fetch_pc_d = jump_target;
                    state_d    = PRIME;
                end else begin
                    exec_pc_d  = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + PC_W'(1);
                end
            end
            DONE: begin
                if (start) begin
                    fetch_pc_d = '0;
                    state_d    = PRIME;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= '0;
            exec_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            exec_pc_q  <= exec_pc_d;
        end
    end

    // Stall re-reads the presented word so imem_rdata stays stable while held.
    always_comb begin
        imem_addr = fetch_pc_q;
        case (state_q)
            IDLE:    imem_addr = fetch_pc_q;
            PRIME:   imem_addr = fetch_pc_q;
            RUN:     imem_addr = stall ? exec_pc_q : fetch_pc_q;
            DONE:    imem_addr = exec_pc_q;
            default: imem_addr = '0;
        endcase
    end

    assign instr_valid = (state_q == RUN);
    assign instr       = instr_valid ? imem_rdata : '0;
    assign pc          = exec_pc_q;
    assign done        = (state_q == DONE);
    assign dbg_state   = state_q;

endmodule
